// File: rtl/hex_digit_scanner.sv
// Time-multiplexes a multi-digit hex value onto a shared nibble bus with a one-hot digit enable and leading-zero blanking.
// Loads are buffered in a one-deep pending register and committed only at the frame boundary.
module hex_digit_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE      = 1000,
    parameter bit BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_en,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              nib_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    blank,
    output logic                    frame_tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    logic [PW-1:0] r_presc;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_disp;
    logic [DW-1:0] r_pend;
    logic          r_pend_full;
    logic          r_frame_tick;

    logic          w_tick;
    logic          w_wrap;
    logic          w_accept;
    logic          w_commit;
    logic [DW-1:0] w_shifted;
    logic          w_upper_zero;

    assign w_tick   = scan_en && (r_presc == PW'(PRESCALE - 1));
    assign w_wrap   = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_accept = load_valid && !r_pend_full;
    assign w_commit = w_wrap && r_pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            if (scan_en) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + IW'(1);
            end
            // Accept and commit are mutually exclusive: accept needs the pending slot empty, commit needs it full.
            if (w_commit) begin
                r_disp      <= r_pend;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend      <= load_data;
                r_pend_full <= 1'b1;
            end
            r_frame_tick <= w_wrap;
        end
    end

    // Shifting out the digits below idx leaves exactly the digits that decide blanking.
    assign w_shifted    = r_disp >> {r_idx, 2'b00};
    assign w_upper_zero = (w_shifted == '0);

    assign blank      = BLANK_LEADING && (r_idx != '0) && w_upper_zero;
    assign nib_out    = blank ? 4'h0 : w_shifted[3:0];
    assign digit_en   = blank ? '0 : (NUM_DIGITS'(1) << r_idx);
    assign load_ready = !r_pend_full;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Bench for hex_digit_scanner: two instances (PRESCALE=4 and PRESCALE=1) checked against a frame-position reference model.
module tb_hex_digit_scanner;
    localparam int N   = 4;
    localparam int PR0 = 4;
    localparam int PR1 = 1;

    logic        clk;
    logic        rst_n;
    logic [1:0]  scan_en;
    logic [1:0]  load_valid;
    logic [1:0]  load_ready;
    logic [1:0]  blank;
    logic [1:0]  frame_tick;
    logic [15:0] load_data [2];
    logic [3:0]  nib [2];
    logic [3:0]  den [2];

    hex_digit_scanner #(.NUM_DIGITS(N), .PRESCALE(PR0), .BLANK_LEADING(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en[0]), .load_valid(load_valid[0]),
        .load_data(load_data[0]), .load_ready(load_ready[0]), .nib_out(nib[0]),
        .digit_en(den[0]), .blank(blank[0]), .frame_tick(frame_tick[0])
    );

    hex_digit_scanner #(.NUM_DIGITS(N), .PRESCALE(PR1), .BLANK_LEADING(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en[1]), .load_valid(load_valid[1]),
        .load_data(load_data[1]), .load_ready(load_ready[1]), .nib_out(nib[1]),
        .digit_en(den[1]), .blank(blank[1]), .frame_tick(frame_tick[1])
    );

    // Reference model: position within the frame is a single scan-cycle counter.
    int          m_cnt [2];
    logic [15:0] m_disp [2];
    logic [15:0] m_pend [2];
    logic        m_full [2];
    logic        m_ft [2];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] dummy;

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   mix_frames;
    logic has1;
    logic has2;
    int   acc1_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int presc_of(int d);
        return (d == 0) ? PR0 : PR1;
    endfunction

    function automatic logic [10:0] expv(int d);
        int          idx;
        logic        bl;
        logic [3:0]  nb;
        logic [3:0]  de;
        idx = m_cnt[d] / presc_of(d);
        bl  = (idx > 0);
        for (int j = 0; j < N; j++) begin
            if (j >= idx && ((m_disp[d] >> (4 * j)) & 16'hF) != 16'h0) bl = 1'b0;
        end
        nb = bl ? 4'h0 : 4'(m_disp[d] >> (4 * idx));
        de = bl ? 4'h0 : 4'(1 << idx);
        return {nb, de, bl, m_ft[d], !m_full[d]};
    endfunction

    function automatic logic [10:0] actv(int d);
        return {nib[d], den[d], blank[d], frame_tick[d], load_ready[d]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_disp[d] = 16'h0;
            m_pend[d] = 16'h0;
            m_full[d] = 1'b0;
            m_ft[d]   = 1'b0;
        end
        q0.delete();
        q1.delete();
        has1 = 1'b0;
        has2 = 1'b0;
    endtask

    task automatic drive();
        load_valid[0] = (q0.size() > 0);
        load_data[0]  = load_valid[0] ? q0[0] : 16'($urandom);
        load_valid[1] = (q1.size() > 0);
        load_data[1]  = load_valid[1] ? q1[0] : 16'($urandom);
    endtask

    task automatic step();
        logic [1:0]  sv;
        logic [1:0]  lv;
        logic [1:0]  hs;
        logic [15:0] ld [2];
        logic        wrap;
        logic        acc;
        int          fl;
        sv = scan_en;
        lv = load_valid;
        hs = load_valid & load_ready;
        ld = load_data;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            fl   = N * presc_of(d);
            wrap = sv[d] && (m_cnt[d] == fl - 1);
            acc  = lv[d] && !m_full[d];
            if (wrap && m_full[d]) begin
                m_disp[d] = m_pend[d];
                m_full[d] = 1'b0;
            end
            if (acc) begin
                m_pend[d] = ld[d];
                m_full[d] = 1'b1;
            end
            m_ft[d] = wrap;
            if (sv[d]) m_cnt[d] = (m_cnt[d] + 1) % fl;
        end
        if (hs[0]) dummy = q0.pop_front();
        if (hs[1]) begin
            dummy = q1.pop_front();
            acc1_cnt++;
        end
        if (frame_tick[0]) begin
            if (has1 && has2) mix_frames++;
            has1 = 1'b0;
            has2 = 1'b0;
        end
        if (den[0] != 4'h0) begin
            has1 = has1 | (nib[0] == 4'h1);
            has2 = has2 | (nib[0] == 4'h2);
        end
        drive();
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (actv(d) !== 11'b0000_0001_0_0_1) begin
                n_fail++;
                $display("FAIL reset_hold dut%0d: got %b expected %b", d, actv(d), 11'b0000_0001_0_0_1);
            end
        end
        rst_n   = 1'b1;
        scan_en = 2'b11;
        q0.push_back(16'h1234);
        q1.push_back(16'h1234);
        drive();
        repeat (22) begin
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (actv(d) !== expv(d)) begin
                    n_fail++;
                    $display("FAIL reset_run dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                end
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (actv(d) !== 11'b0000_0001_0_0_1) begin
                n_fail++;
                $display("FAIL reset_async dut%0d: got %b expected %b", d, actv(d), 11'b0000_0001_0_0_1);
            end
        end
        model_reset();
        drive();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [15:0] val;
        logic [9:0]  exp;
        logic [9:0]  got;
        int          n;
        logic        found;
        val = 16'h1A3F;
        q0.push_back(val);
        q1.push_back(val);
        drive();
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            step();
            n++;
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (actv(d) !== expv(d)) begin
                    n_fail++;
                    $display("FAIL scan_sync dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                end
            end
            if (frame_tick[0] && m_disp[0] == val) found = 1'b1;
        end
        n_chk++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_timeout: got %b expected 1", found);
        end
        for (int k = 0; k < 16; k++) begin
            exp = {4'(val >> (4 * (k / 4))), 4'(1 << (k / 4)), 1'b0, (k == 0)};
            got = {nib[0], den[0], blank[0], frame_tick[0]};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL scan_seq k=%0d: got %h expected %h", k, got, exp);
            end
            step();
        end
        n_chk++;
        if (frame_tick[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_ft_period: got %b expected 1", frame_tick[0]);
        end
    endtask

    task automatic test_blanking();
        logic [15:0] vals [3];
        logic [3:0]  masks [3];
        logic [8:0]  exp;
        logic [8:0]  got;
        logic        bl;
        int          n;
        logic        found;
        vals  = '{16'h0007, 16'h0000, 16'h0100};
        masks = '{4'b1110, 4'b1110, 4'b1000};
        for (int v = 0; v < 3; v++) begin
            q0.push_back(vals[v]);
            q1.push_back(vals[v]);
            drive();
            n = 0;
            found = 1'b0;
            while (!found && n < 100) begin
                step();
                n++;
                for (int d = 0; d < 2; d++) begin
                    n_chk++;
                    if (actv(d) !== expv(d)) begin
                        n_fail++;
                        $display("FAIL blank_sync dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                    end
                end
                if (frame_tick[0] && m_disp[0] == vals[v] && !m_full[0]) found = 1'b1;
            end
            n_chk++;
            if (found !== 1'b1) begin
                n_fail++;
                $display("FAIL blank_timeout v=%h: got %b expected 1", vals[v], found);
            end
            for (int k = 0; k < 16; k++) begin
                bl  = masks[v][k / 4];
                exp = {bl ? 4'h0 : 4'(vals[v] >> (4 * (k / 4))), bl ? 4'h0 : 4'(1 << (k / 4)), bl};
                got = {nib[0], den[0], blank[0]};
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL blank_seq v=%h k=%0d: got %h expected %h", vals[v], k, got, exp);
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        logic found;
        mix_frames = 0;
        n = 0;
        while (m_cnt[0] != 6 && n < 40) begin
            step();
            n++;
        end
        q0.push_back(16'h1111);
        q0.push_back(16'h2222);
        q1.push_back(16'h1111);
        q1.push_back(16'h2222);
        drive();
        step();
        n_chk++;
        if (load_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_a_taken: got %b expected 0", load_ready[0]);
        end
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            n++;
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (actv(d) !== expv(d)) begin
                    n_fail++;
                    $display("FAIL b2b_a dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                end
            end
            if (frame_tick[0] && m_disp[0] == 16'h1111) found = 1'b1;
        end
        n_chk++;
        if ({found, load_ready[0], nib[0]} !== {1'b1, 1'b1, 4'h1}) begin
            n_fail++;
            $display("FAIL b2b_a_commit: got %b expected %b", {found, load_ready[0], nib[0]}, {1'b1, 1'b1, 4'h1});
        end
        step();
        n_chk++;
        if (load_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_b_taken: got %b expected 0", load_ready[0]);
        end
        n = 0;
        found = 1'b0;
        while (n < 40) begin
            step();
            n++;
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (actv(d) !== expv(d)) begin
                    n_fail++;
                    $display("FAIL b2b_b dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                end
            end
            if (frame_tick[0] && m_disp[0] == 16'h2222) found = 1'b1;
        end
        n_chk++;
        if ({found, mix_frames} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL b2b_no_mix: got found=%b mixed=%0d expected found=1 mixed=0", found, mix_frames);
        end
    endtask

    task automatic test_scan_hold();
        int         n;
        int         c;
        logic       found;
        logic [8:0] snap;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_full[0] || m_full[1] || (m_cnt[0] % 4) != 2) && n < 200) begin
            step();
            n++;
        end
        c = m_cnt[0];
        scan_en = 2'b00;
        q0.push_back(16'hBEEF);
        q1.push_back(16'hBEEF);
        drive();
        snap = {nib[0], den[0], blank[0]};
        repeat (20) begin
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (actv(d) !== expv(d)) begin
                    n_fail++;
                    $display("FAIL hold_model dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                end
            end
            n_chk++;
            if ({nib[0], den[0], blank[0]} !== snap) begin
                n_fail++;
                $display("FAIL hold_frozen cyc %0d: got %h expected %h", cyc, {nib[0], den[0], blank[0]}, snap);
            end
        end
        n_chk++;
        if (load_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_pend: got %b expected 0", load_ready[0]);
        end
        scan_en = 2'b11;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            n++;
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (actv(d) !== expv(d)) begin
                    n_fail++;
                    $display("FAIL hold_resume dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                end
            end
            if (frame_tick[0]) found = 1'b1;
        end
        n_chk++;
        if ({n, nib[0], den[0]} !== {16 - c, 4'hF, 4'b0001}) begin
            n_fail++;
            $display("FAIL hold_wrap: got cycles=%0d nib=%h en=%b expected cycles=%0d nib=f en=0001", n, nib[0], den[0], 16 - c);
        end
    endtask

    task automatic test_prescale1();
        int         n;
        int         last_ft;
        int         nft;
        logic [3:0] prev_den;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_full[0] || m_full[1]) && n < 200) begin
            step();
            n++;
        end
        for (int i = 0; i < 20; i++) q1.push_back({4'($urandom_range(1, 15)), 12'($urandom)});
        drive();
        acc1_cnt = 0;
        last_ft  = 0;
        nft      = 0;
        prev_den = den[1];
        repeat (48) begin
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (actv(d) !== expv(d)) begin
                    n_fail++;
                    $display("FAIL p1_model dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                end
            end
            n_chk++;
            if (den[1] === prev_den) begin
                n_fail++;
                $display("FAIL p1_idx_step cyc %0d: got %b expected a change from %b", cyc, den[1], prev_den);
            end
            prev_den = den[1];
            if (frame_tick[1]) begin
                nft++;
                if (nft > 2) begin
                    n_chk++;
                    if ({cyc - last_ft, acc1_cnt} !== {32'd4, 32'd1}) begin
                        n_fail++;
                        $display("FAIL p1_frame cyc %0d: got period=%0d accepts=%0d expected period=4 accepts=1", cyc, cyc - last_ft, acc1_cnt);
                    end
                end
                last_ft  = cyc;
                acc1_cnt = 0;
            end
        end
        q1.delete();
        drive();
    endtask

    task automatic test_random();
        repeat (400) begin
            scan_en[0] = ($urandom_range(0, 3) != 0);
            scan_en[1] = ($urandom_range(0, 3) != 0);
            if (q0.size() < 3 && $urandom_range(0, 9) == 0) q0.push_back(16'($urandom) >> (4 * $urandom_range(0, 4)));
            if (q1.size() < 3 && $urandom_range(0, 5) == 0) q1.push_back(16'($urandom) >> (4 * $urandom_range(0, 4)));
            drive();
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (actv(d) !== expv(d)) begin
                    n_fail++;
                    $display("FAIL rand dut%0d cyc %0d: got %h expected %h", d, cyc, actv(d), expv(d));
                end
            end
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        cyc        = 0;
        mix_frames = 0;
        acc1_cnt   = 0;
        dummy      = 16'h0;
        rst_n      = 1'b0;
        scan_en    = 2'b00;
        model_reset();
        drive();
        test_reset();
        test_scan();
        test_blanking();
        test_back_to_back();
        test_scan_hold();
        test_prescale1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
